// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a busy scoreboard.
//
// NRD combinational read ports and two write (retire) lanes. Each register also
// has a busy bit: set when a producer is issued and cleared when its result is
// written back. Register 0 always reads zero and is never busy.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   rs_addr / rs_data     read addresses and data, port k in slice k
//   rs_busy               busy bit of each read port's register
//   we0/wa0/wd0           write lane 0
//   we1/wa1/wd1           write lane 1 (wins over lane 0 on the same address)
//   issue_valid/issue_rd  mark a destination busy
//   flush                 clear all busy bits (register data untouched)
//   any_busy              OR of all busy bits
//
// Optional feature: define REGFILE_BYPASS_EN to forward write data to the read
// ports in the same cycle. Without it, reads come from storage only.

module regfile_mp #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NRD*ADDR_W-1:0]  rs_addr,
  output logic [NRD*XLEN-1:0]    rs_data,
  output logic [NRD-1:0]         rs_busy,
  input  logic                   we0,
  input  logic [ADDR_W-1:0]      wa0,
  input  logic [XLEN-1:0]        wd0,
  input  logic                   we1,
  input  logic [ADDR_W-1:0]      wa1,
  input  logic [XLEN-1:0]        wd1,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_rd,
  input  logic                   flush,
  output logic                   any_busy
);

  localparam int unsigned NRegs = 2 ** ADDR_W;

  logic [XLEN-1:0]  regs_q [NRegs];
  logic [NRegs-1:0] busy_q, busy_d;

  logic wr0, wr1, iss;
  assign wr0 = we0 && (wa0 != '0);
  assign wr1 = we1 && (wa1 != '0);
  assign iss = issue_valid && (issue_rd != '0);

  // Lane 1 is written after lane 0 so it wins on a shared address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wr0) regs_q[wa0] <= wd0;
      if (wr1) regs_q[wa1] <= wd1;
    end
  end

  // Order matters: flush, then writeback clears, then issue sets, so a new
  // producer issued alongside a writeback or flush keeps its busy bit.
  always_comb begin
    busy_d = busy_q;
    if (flush) busy_d = '0;
    if (wr0) busy_d[wa0] = 1'b0;
    if (wr1) busy_d[wa1] = 1'b0;
    if (iss) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign any_busy = |busy_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   stored;
    logic [XLEN-1:0]   data;
    logic              busy;

    assign addr   = rs_addr[k*ADDR_W +: ADDR_W];
    assign stored = (addr == '0) ? '0 : regs_q[addr];

`ifdef REGFILE_BYPASS_EN
    logic hit0, hit1;
    assign hit0 = wr0 && (wa0 == addr);
    assign hit1 = wr1 && (wa1 == addr);

    always_comb begin
      data = stored;
      busy = busy_q[addr];
      if (hit1) begin
        data = wd1;
      end else if (hit0) begin
        data = wd0;
      end
      // A same-cycle issue to this register keeps the stored busy view.
      if ((hit0 || hit1) && !(iss && (issue_rd == addr))) begin
        busy = 1'b0;
      end
    end
`else
    assign data = stored;
    assign busy = busy_q[addr];
`endif

    assign rs_data[k*XLEN +: XLEN] = data;
    assign rs_busy[k]              = busy;
  end

endmodule
